// File: rtl/axi2per_res_buffer.sv
// axi2per response buffer: captures the single-beat peripheral response for the
// pending transaction and returns it on AXI R (reads) or B (writes), holding it
// until the master accepts it, then pulses completion back to the request stage.
module axi2per_res_buffer #(
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      per_master_r_valid_i,
  input  logic                      per_master_r_opc_i,
  input  logic [PER_ID_WIDTH-1:0]   per_master_r_id_i,
  input  logic [31:0]               per_master_r_rdata_i,

  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  output logic                      trans_r_valid_o,

  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,

  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i
);

  typedef enum logic [1:0] {IDLE, WAIT_PER, SEND_R, SEND_B} state_t;

  state_t                    state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic                      we_q;    // 1 = read (peripheral convention)
  logic                      lane_q;  // address bit 2 selects the 32-bit half
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [1:0]                resp_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_lane;
  logic                      r_hs, b_hs;

  // Peripheral ID and the address bits other than [2] carry no meaning here.
  logic unused_in;
  assign unused_in = ^{per_master_r_id_i, trans_add_i};

  // Place the 32-bit peripheral word into the 64-bit beat on the addressed half.
  assign rdata_lane = lane_q ? {per_master_r_rdata_i, 32'h0}
                             : {32'h0, per_master_r_rdata_i};

  assign r_hs = (state_q == SEND_R) && axi_slave_r_ready_i;
  assign b_hs = (state_q == SEND_B) && axi_slave_b_ready_i;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (trans_req_i)          state_d = WAIT_PER;
      WAIT_PER: if (per_master_r_valid_i) state_d = we_q ? SEND_R : SEND_B;
      SEND_R:   if (axi_slave_r_ready_i)  state_d = IDLE;
      SEND_B:   if (axi_slave_b_ready_i)  state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // State register plus transaction/response capture; reset discards any held response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      we_q    <= 1'b0;
      lane_q  <= 1'b0;
      data_q  <= '0;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && trans_req_i) begin
        id_q   <= trans_id_i;
        we_q   <= trans_we_i;
        lane_q <= trans_add_i[2];
      end
      if (state_q == WAIT_PER && per_master_r_valid_i) begin
        resp_q <= per_master_r_opc_i ? 2'b10 : 2'b00;
        data_q <= we_q ? rdata_lane : '0;
      end
    end
  end

  assign trans_r_valid_o     = r_hs | b_hs;

  assign axi_slave_r_valid_o = (state_q == SEND_R);
  assign axi_slave_r_last_o  = (state_q == SEND_R);
  assign axi_slave_r_data_o  = data_q;
  assign axi_slave_r_resp_o  = resp_q;
  assign axi_slave_r_id_o    = id_q;
  assign axi_slave_r_user_o  = '0;

  assign axi_slave_b_valid_o = (state_q == SEND_B);
  assign axi_slave_b_resp_o  = resp_q;
  assign axi_slave_b_id_o    = id_q;
  assign axi_slave_b_user_o  = '0;

endmodule

// File: tb/tb_axi2per_res_buffer.sv
// Bench for axi2per_res_buffer: directed test-plan transactions followed by
// randomized ones, each checked against expected values computed per transaction.
module tb_axi2per_res_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        per_valid, per_opc;
  logic [4:0]  per_id;
  logic [31:0] per_rdata;
  logic        trans_req, trans_we;
  logic [2:0]  trans_id;
  logic [31:0] trans_add;
  logic        trans_r_valid;
  logic        r_valid, r_last, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [2:0]  r_id;
  logic [5:0]  r_user;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic [2:0]  b_id;
  logic [5:0]  b_user;

  int n_chk = 0;
  int n_fail = 0;

  axi2per_res_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .per_master_r_valid_i(per_valid), .per_master_r_opc_i(per_opc),
    .per_master_r_id_i(per_id), .per_master_r_rdata_i(per_rdata),
    .trans_req_i(trans_req), .trans_we_i(trans_we), .trans_id_i(trans_id),
    .trans_add_i(trans_add), .trans_r_valid_o(trans_r_valid),
    .axi_slave_r_valid_o(r_valid), .axi_slave_r_data_o(r_data),
    .axi_slave_r_resp_o(r_resp), .axi_slave_r_last_o(r_last),
    .axi_slave_r_id_o(r_id), .axi_slave_r_user_o(r_user),
    .axi_slave_r_ready_i(r_ready),
    .axi_slave_b_valid_o(b_valid), .axi_slave_b_resp_o(b_resp),
    .axi_slave_b_id_o(b_id), .axi_slave_b_user_o(b_user),
    .axi_slave_b_ready_i(b_ready)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Held response must be visible on exactly one channel with the expected fields.
  task automatic check_hold(input logic we, input logic [2:0] id,
                            input logic [63:0] ed, input logic [1:0] er);
    chk("r_valid", r_valid, we);
    chk("b_valid", b_valid, !we);
    chk("r_last", r_last, we);
    chk("r_user", r_user, 0);
    chk("b_user", b_user, 0);
    if (we) begin
      chk("r_data", r_data, ed);
      chk("r_resp", r_resp, er);
      chk("r_id", r_id, id);
    end else begin
      chk("b_resp", b_resp, er);
      chk("b_id", b_id, id);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_r_valid"}, r_valid, 0);
    chk({tag, "_b_valid"}, b_valid, 0);
    chk({tag, "_r_last"}, r_last, 0);
    chk({tag, "_trans_r_valid"}, trans_r_valid, 0);
  endtask

  // One full transaction; entered and left just after a falling edge with readies low.
  // d = peripheral latency beyond the minimum, k = backpressure cycles,
  // spur = inject ignored peripheral pulses, rst_mid = reset instead of handshake.
  task automatic txn(input logic we, input logic [2:0] id, input logic [31:0] add,
                     input logic [31:0] rdata, input logic opc, input int d,
                     input int k, input logic spur, input logic rst_mid);
    logic [63:0] ed;
    logic [1:0]  er;
    ed = we ? (64'(rdata) << (add[2] ? 32 : 0)) : 64'h0;
    er = opc ? 2'b10 : 2'b00;
    // Request cycle; a same-cycle peripheral pulse lands in IDLE and must be ignored.
    trans_req = 1'b1; trans_we = we; trans_id = id; trans_add = add;
    per_valid = spur; per_rdata = $urandom; per_opc = 1'($urandom);
    @(negedge clk_i);
    trans_req = 1'b0; per_valid = 1'b0;
    trans_we = 1'($urandom); trans_id = 3'($urandom); trans_add = $urandom;
    repeat (d) begin
      #1 check_idle("wait");
      trans_req = 1'($urandom);  // ignored while waiting on the peripheral
      @(negedge clk_i);
      trans_req = 1'b0;
    end
    per_valid = 1'b1; per_rdata = rdata; per_opc = opc;
    @(negedge clk_i);
    per_valid = 1'b0; per_rdata = $urandom; per_opc = 1'($urandom);
    repeat (k) begin
      #1 check_hold(we, id, ed, er);
      per_valid = spur & 1'($urandom);
      if (we) b_ready = 1'($urandom); else r_ready = 1'($urandom);
      #1 chk("no_early_done", trans_r_valid, 0);
      @(negedge clk_i);
      per_valid = 1'b0; r_ready = 1'b0; b_ready = 1'b0;
    end
    #1 check_hold(we, id, ed, er);
    if (rst_mid) begin
      rst_i = 1'b1;
      #1 chk("rst_no_done", trans_r_valid, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1 check_idle("post_rst");
      chk("post_rst_r_data", r_data, 0);
      chk("post_rst_r_id", r_id, 0);
      chk("post_rst_r_resp", r_resp, 0);
    end else begin
      if (we) r_ready = 1'b1; else b_ready = 1'b1;
      #1 chk("done_pulse", trans_r_valid, 1);
      check_hold(we, id, ed, er);
      @(negedge clk_i);
      r_ready = 1'b0; b_ready = 1'b0;
      #1 check_idle("after_hs");
    end
  endtask

  initial begin
    rst_i = 1'b1; per_valid = 1'b0; per_opc = 1'b0; per_id = '0; per_rdata = '0;
    trans_req = 1'b0; trans_we = 1'b0; trans_id = '0; trans_add = '0;
    r_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(negedge clk_i);
    #1 check_idle("reset");
    chk("reset_r_data", r_data, 0);
    chk("reset_r_id", r_id, 0);
    chk("reset_b_resp", b_resp, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed cases from the test plan.
    txn(1'b1, 3'h5, 32'h1000_0000, 32'hDEAD_BEEF, 1'b0, 0, 0, 1'b0, 1'b0);  // read lower lane
    txn(1'b1, 3'h1, 32'h1000_0004, 32'hCAFE_F00D, 1'b0, 0, 0, 1'b0, 1'b0);  // read upper lane
    txn(1'b0, 3'h2, 32'h2000_0000, 32'h0,         1'b0, 1, 4, 1'b0, 1'b0);  // write, backpressure
    txn(1'b1, 3'h3, 32'h0000_0008, 32'h1234_5678, 1'b1, 0, 0, 1'b0, 1'b0);  // read error
    txn(1'b0, 3'h4, 32'h0000_000C, 32'h0,         1'b1, 0, 0, 1'b0, 1'b0);  // write error
    txn(1'b1, 3'h6, 32'h0000_0000, 32'hA5A5_5A5A, 1'b0, 0, 2, 1'b0, 1'b1);  // reset mid SEND_R
    txn(1'b1, 3'h7, 32'h0000_0004, 32'h0BAD_F00D, 1'b0, 0, 0, 1'b0, 1'b0);  // recovers after reset
    txn(1'b1, 3'h1, 32'h0000_0000, 32'h1111_2222, 1'b0, 0, 0, 1'b1, 1'b0);  // back-to-back read
    txn(1'b0, 3'h2, 32'h0000_0004, 32'h0,         1'b0, 0, 2, 1'b1, 1'b0);  // then write, spurious pulses

    // Randomized transactions.
    for (int i = 0; i < 150; i++) begin
      txn(1'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
          1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi2per_res_buffer.md
Name: axi2per_res_buffer

Overview:
- Response-side companion of the AXI-to-peripheral request stage in the axi2per bridge.
- Accepts the pending-transaction notification from the request stage and captures the single-beat peripheral response.
- Returns the response on the AXI R channel (reads) or B channel (writes), holding it until the AXI master accepts it.
- On that accept, pulses completion back to the request stage so it can issue the next transaction.

Parameters:
- PER_ID_WIDTH, 5, peripheral response ID width (ignored internally).
- AXI_ADDR_WIDTH, 32, width of the transaction address.
- AXI_DATA_WIDTH, 64, AXI data width. Only 64 is supported.
- AXI_USER_WIDTH, 6, AXI user field width.
- AXI_ID_WIDTH, 3, AXI ID width.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- per_master_r_valid_i  in  1  peripheral response valid; single-cycle pulse.
- per_master_r_opc_i  in  1  response status: 0 = OK, 1 = error.
- per_master_r_id_i  in  PER_ID_WIDTH  peripheral response ID (unused).
- per_master_r_rdata_i  in  32  peripheral read data.
- trans_req_i  in  1  pending-transaction notification from the request stage.
- trans_we_i  in  1  transaction type: 1 = read, 0 = write (peripheral convention).
- trans_id_i  in  AXI_ID_WIDTH  AXI ID of the transaction.
- trans_add_i  in  AXI_ADDR_WIDTH  transaction address.
- trans_r_valid_o  out  1  completion pulse to the request stage.
- axi_slave_r_valid_o  out  1  AXI read data valid.
- axi_slave_r_data_o  out  AXI_DATA_WIDTH  AXI read data.
- axi_slave_r_resp_o  out  2  AXI read response.
- axi_slave_r_last_o  out  1  AXI read last beat.
- axi_slave_r_id_o  out  AXI_ID_WIDTH  AXI read ID.
- axi_slave_r_user_o  out  AXI_USER_WIDTH  AXI read user field.
- axi_slave_r_ready_i  in  1  AXI read ready.
- axi_slave_b_valid_o  out  1  AXI write response valid.
- axi_slave_b_resp_o  out  2  AXI write response.
- axi_slave_b_id_o  out  AXI_ID_WIDTH  AXI write response ID.
- axi_slave_b_user_o  out  AXI_USER_WIDTH  AXI write response user field.
- axi_slave_b_ready_i  in  1  AXI write response ready.

Behaviour:
- Reset (rst_i = 1 at a clock edge):
  - State goes to IDLE.
  - All outputs and all internal registers (id, type, lane, data, resp) go to 0.
  - Reset dominates every other event, including mid-transaction; any held response is discarded.
- State IDLE:
  - trans_req_i = 1 latches trans_id_i, trans_we_i and trans_add_i[2]; next state is WAIT_PER.
  - per_master_r_valid_i is ignored.
- State WAIT_PER:
  - per_master_r_valid_i = 1 registers the response; next state is SEND_R if the latched type is read, else SEND_B.
  - Response code: opc 0 gives 2'b00 (OKAY); opc 1 gives 2'b10 (SLVERR).
  - Read data placement: latched add[2] = 0 puts rdata in r_data[31:0] with [63:32] = 0; add[2] = 1 puts rdata in [63:32] with [31:0] = 0.
  - Write responses store no data.
  - trans_req_i is ignored.
- Latency: a response pulse in cycle N gives r_valid/b_valid high from cycle N+1.
  - Earliest legal per_master_r_valid_i is the cycle after trans_req_i.
  - A same-cycle pulse arrives in IDLE and is ignored.
- State SEND_R:
  - axi_slave_r_valid_o = 1 and r_last = 1.
  - r_id, r_data and r_resp come from the registers and stay stable until the handshake.
  - Handshake cycle (r_ready_i = 1): trans_r_valid_o = 1 combinationally in that same cycle; next state is IDLE, and r_valid is 0 from the next cycle.
- State SEND_B: same as SEND_R, using the b_* ports and b_ready_i.
- Output rules:
  - r_valid and b_valid are never both 1.
  - valid never drops without a handshake.
  - r_last = 0 outside SEND_R.
  - r_user and b_user are always 0.
  - Data, id and resp may read 0 when the matching valid is 0.
- trans_r_valid_o is exactly one cycle per transaction and is 0 in all other states.
- Peripheral responses arriving in SEND_R or SEND_B are ignored.
- Throughput:
  - After handshake cycle M, a new trans_req_i is accepted at M+1.
  - With zero peripheral latency and ready held high, one transaction completes every 3 cycles.
- Backpressure: the response is held indefinitely while ready = 0; there is no timeout.

Test Plan:
- Read, lower lane:
  - Stimulus: trans_req, we = 1, id = 3'h5, add = 32'h1000_0000; one cycle later r_valid with rdata = 32'hDEAD_BEEF, opc = 0; r_ready held high.
  - Response: r_valid high the next cycle with r_data = 64'h0000_0000_DEAD_BEEF, r_resp = 00, r_id = 5, r_last = 1; trans_r_valid pulses in that same cycle.
- Read, upper lane: add = 32'h1000_0004, rdata = 32'hCAFE_F00D -> r_data = 64'hCAFE_F00D_0000_0000.
- Write with backpressure:
  - Stimulus: we = 0, id = 2; opc = 0; b_ready low for 4 cycles.
  - Response: b_valid high with b_resp = 00 and b_id = 2, stable for 4 cycles; single trans_r_valid on the b_ready cycle; r_valid stays 0 throughout.
- Error response: a read with opc = 1 gives r_resp = 2'b10; a write with opc = 1 gives b_resp = 2'b10.
- Reset mid-operation:
  - Stimulus: assert rst_i while in SEND_R with r_ready low.
  - Response: r_valid = 0 after the edge and no trans_r_valid; a subsequent read completes normally.
- Back-to-back and spurious traffic:
  - Stimulus: read followed by write, each trans_req issued the cycle after the previous trans_r_valid, with a spurious per_r_valid in IDLE and in SEND_B.
  - Response: spurious pulses are ignored; exactly 2 completions in order, with correct ids.
